// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read streamer: controller states and
// default parameter values.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_RD_LAT    = 1;
  localparam int unsigned DEF_BUF_DEPTH = 4;
  localparam int unsigned DEF_PKT_LEN   = 16;

endpackage

// File: rtl/fifo_rd_skid.sv
// Circular landing buffer with a registered head entry; the caller guarantees
// it never pushes into a full buffer.
module fifo_rd_skid #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic [$clog2(DEPTH+1)-1:0]   occ_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pop_ok = pop_i && (occ_q != '0);
    rd_d   = pop_ok ? nxt(rd_q) : rd_q;
    wr_d   = push_i ? nxt(wr_q) : wr_q;
    occ_d  = occ_q;
    if (push_i && !pop_ok)      occ_d = occ_q + 1'b1;
    else if (!push_i && pop_ok) occ_d = occ_q - 1'b1;
    // A byte pushed into the slot that becomes the head bypasses storage.
    head_d = (push_i && (wr_q == rd_d)) ? push_data_i : mem_q[rd_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q   <= '0;
      wr_q   <= '0;
      occ_q  <= '0;
      head_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      occ_q  <= occ_d;
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end

  assign head_o = head_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_rd_streamer.sv
// Pulls bytes from a fixed-latency FIFO read port under credit control and
// streams them out as valid/ready packets of PKT_LEN bytes.
module fifo_rd_streamer
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned RD_LAT    = DEF_RD_LAT,
  parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int unsigned PKT_LEN   = DEF_PKT_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_enable,
  output logic              o_rden,
  input  logic              i_empty,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              o_busy,
  output logic [15:0]       o_pkt_cnt
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH+1);
  localparam int unsigned IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN-1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   infl_q, infl_d;
  logic [CNT_W-1:0]   occ;
  logic [RD_LAT-1:0]  land_pipe_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        pkt_q, pkt_d;
  logic               land, xfer;

  assign land = land_pipe_q[RD_LAT-1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_enable) state_d = RUN;
      RUN:     if (!i_enable) state_d = FLUSH;
      FLUSH:   if ((infl_q == '0) && (occ == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Credits count both buffered and in-flight bytes, so every landed byte has a slot.
  assign o_rden = (state_q == RUN) && !i_empty &&
                  (((CNT_W+1)'(infl_q) + (CNT_W+1)'(occ)) < (CNT_W+1)'(BUF_DEPTH));

  always_comb begin
    infl_d = infl_q;
    if (o_rden && !land)      infl_d = infl_q + 1'b1;
    else if (!o_rden && land) infl_d = infl_q - 1'b1;
  end

  assign m_valid = (occ != '0);
  assign m_last  = m_valid && (idx_q == LAST_IDX);
  assign xfer    = m_valid && m_ready;
  assign o_busy  = (state_q != IDLE);

  always_comb begin
    idx_d = idx_q;
    pkt_d = pkt_q;
    if (xfer) begin
      idx_d = m_last ? '0 : idx_q + 1'b1;
      if (m_last) pkt_d = pkt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      infl_q      <= '0;
      land_pipe_q <= '0;
      idx_q       <= '0;
      pkt_q       <= '0;
    end else begin
      state_q     <= state_d;
      infl_q      <= infl_d;
      land_pipe_q <= (land_pipe_q << 1) | RD_LAT'(o_rden);
      idx_q       <= idx_d;
      pkt_q       <= pkt_d;
    end
  end

  fifo_rd_skid #(
    .WIDTH (DATA_W),
    .DEPTH (BUF_DEPTH)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .push_i      (land),
    .push_data_i (i_rdata),
    .pop_i       (xfer),
    .head_o      (m_data),
    .occ_o       (occ)
  );

  assign o_pkt_cnt = pkt_q;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer: models an RD_LAT=1 FIFO and checks
// every presented byte against an expected stream.
module tb_fifo_rd_streamer;
  import fifo_rd_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_enable = 1'b0;
  logic        o_rden;
  logic        i_empty;
  logic [7:0]  i_rdata = 8'h00;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic        m_last;
  logic        o_busy;
  logic [15:0] o_pkt_cnt;

  fifo_rd_streamer #(
    .DATA_W    (8),
    .RD_LAT    (1),
    .BUF_DEPTH (4),
    .PKT_LEN   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_enable  (i_enable),
    .o_rden    (o_rden),
    .i_empty   (i_empty),
    .i_rdata   (i_rdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .o_busy    (o_busy),
    .o_pkt_cnt (o_pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rden_cnt = 0;
  int first_rden = -1;
  int first_valid = -1;
  int last_xfer = -1;
  logic mon_on = 1'b0;
  logic [8:0] exp_q [$];

  // Upstream FIFO model: one cycle read latency.
  logic [7:0] fmem [256];
  int fifo_rd = 0;
  int fifo_wr = 0;
  assign i_empty = (fifo_rd == fifo_wr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_rden) begin
      i_rdata <= fmem[fifo_rd[7:0]];
      fifo_rd <= fifo_rd + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (o_rden) begin
        rden_cnt++;
        if (first_rden < 0) first_rden = cyc;
      end
      if (i_empty) chk("rden_while_empty", {31'd0, o_rden}, 32'd0);
      if (m_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (exp_q.size() == 0) chk("spurious_byte", {23'd0, m_last, m_data}, 32'h1FF);
        else begin
          chk("head", {23'd0, m_last, m_data}, {23'd0, exp_q[0]});
          if (m_ready) begin
            void'(exp_q.pop_front());
            last_xfer = cyc;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Appends n bytes to the FIFO; the first nexp are expected out, with
  // m_last where the packet index (starting at idx0) reaches 15.
  task automatic load(input int n, input int base, input int nexp, input int idx0);
    for (int k = 0; k < n; k++) begin
      fmem[fifo_wr[7:0]] = 8'(base + k);
      fifo_wr = fifo_wr + 1;
      if (k < nexp) exp_q.push_back({((idx0 + k) % 16) == 15, 8'(base + k)});
    end
  endtask

  task automatic wait_exp(input string tag, input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (o_busy && n < bound) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, o_busy}, 32'd0);
  endtask

  logic [3:0] bp_pat;

  initial begin
    bp_pat = 4'b1001;
    // Reset state
    tick(); tick();
    chk("rst_rden", {31'd0, o_rden}, 0);
    chk("rst_valid", {31'd0, m_valid}, 0);
    chk("rst_data", {24'd0, m_data}, 0);
    chk("rst_last", {31'd0, m_last}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_pkt", {16'd0, o_pkt_cnt}, 0);
    reset = 1'b0;
    mon_on = 1'b1;
    tick();

    // Streaming: 32 bytes, full rate
    load(32, 8'h00, 32, 0);
    m_ready = 1'b1;
    i_enable = 1'b1;
    wait_exp("stream_timeout", 100);
    chk("stream_pkt", {16'd0, o_pkt_cnt}, 2);
    chk("stream_latency", 32'(first_valid - first_rden), 2);
    chk("stream_rate", 32'(last_xfer - first_valid), 31);
    i_enable = 1'b0;
    wait_idle("stream_idle", 20);

    // Backpressure: credits cap at 4, then ready pattern 1,0,0,1
    m_ready = 1'b0;
    rden_cnt = 0;
    load(8, 8'h40, 8, 0);
    i_enable = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_credit_cap", 32'(rden_cnt), 4);
    chk("bp_valid", {31'd0, m_valid}, 1);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      m_ready = bp_pat[i % 4];
      tick();
    end
    chk("bp_remaining", 32'(exp_q.size()), 0);
    chk("bp_rden_total", 32'(rden_cnt), 8);
    m_ready = 1'b1;
    i_enable = 1'b0;
    wait_idle("bp_idle", 20);

    // Empty boundary: only 3 bytes available
    rden_cnt = 0;
    load(3, 8'h60, 3, 8);
    i_enable = 1'b1;
    wait_exp("empty_timeout", 50);
    tick(); tick(); tick();
    chk("empty_rden_cnt", 32'(rden_cnt), 3);
    chk("empty_valid", {31'd0, m_valid}, 0);
    i_enable = 1'b0;
    wait_idle("empty_idle", 20);

    // Flush with 1 in flight and 2 buffered
    m_ready = 1'b0;
    rden_cnt = 0;
    load(5, 8'h70, 3, 11);
    i_enable = 1'b1;
    tick(); tick(); tick();
    i_enable = 1'b0;
    tick();
    chk("flush_state", {30'd0, dut.state_q}, {30'd0, FLUSH});
    chk("flush_rden", {31'd0, o_rden}, 0);
    chk("flush_busy", {31'd0, o_busy}, 1);
    i_enable = 1'b1;
    tick();
    chk("flush_ignores_en", {30'd0, dut.state_q}, {30'd0, FLUSH});
    i_enable = 1'b0;
    m_ready = 1'b1;
    wait_idle("flush_idle", 50);
    chk("flush_drained", 32'(exp_q.size()), 0);
    chk("flush_rden_cnt", 32'(rden_cnt), 3);
    chk("flush_to_idle", {30'd0, dut.state_q}, {30'd0, IDLE});
    fifo_wr = fifo_rd;

    // Reset mid-packet: after index 5 (byte 0x87), bytes still in flight
    load(12, 8'h80, 8, 14);
    i_enable = 1'b1;
    wait_exp("midrst_timeout", 50);
    mon_on = 1'b0;
    chk("midrst_pkt_before", {16'd0, o_pkt_cnt}, 3);
    reset = 1'b1;
    tick();
    chk("midrst_rden", {31'd0, o_rden}, 0);
    chk("midrst_valid", {31'd0, m_valid}, 0);
    chk("midrst_data", {24'd0, m_data}, 0);
    chk("midrst_last", {31'd0, m_last}, 0);
    chk("midrst_busy", {31'd0, o_busy}, 0);
    chk("midrst_pkt", {16'd0, o_pkt_cnt}, 0);
    reset = 1'b0;
    i_enable = 1'b0;
    fifo_wr = fifo_rd;
    mon_on = 1'b1;
    tick();
    chk("postrst_no_rden", {31'd0, o_rden}, 0);
    load(16, 8'h90, 16, 0);
    i_enable = 1'b1;
    wait_exp("postrst_timeout", 60);
    chk("postrst_pkt", {16'd0, o_pkt_cnt}, 1);
    i_enable = 1'b0;
    wait_idle("postrst_idle", 20);

    // Packet counter wrap
    force dut.pkt_q = 16'hFFFF;
    tick();
    release dut.pkt_q;
    tick();
    chk("wrap_preload", {16'd0, o_pkt_cnt}, 32'hFFFF);
    load(16, 8'hA0, 16, 0);
    i_enable = 1'b1;
    wait_exp("wrap_timeout", 60);
    chk("wrap_pkt", {16'd0, o_pkt_cnt}, 0);
    i_enable = 1'b0;
    wait_idle("wrap_idle", 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
